// File: rtl/param_counter_pkg.sv
// Shared constants and types for the parameterised up/down counter.
package param_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_LOAD = 2'd1,
        ACT_STEP = 2'd2
    } act_e;

endpackage

// File: rtl/param_counter_next.sv
// Combinational next-count and boundary-event detection for one enabled step.
module param_counter_next
    import param_counter_pkg::*;
#(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] i_cur,
    input  logic             i_up,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_limit,
    output logic [WIDTH-1:0] o_next,
    output logic             o_boundary
);

    localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

    logic [WIDTH-1:0] w_next;
    logic             w_boundary;

    // Step result; a value above limit counting down snaps to limit without an event.
    always_comb begin
        w_next     = i_cur;
        w_boundary = 1'b0;
        if (i_up) begin
            if (i_cur < i_limit) begin
                w_next = i_cur + ONE;
            end else begin
                w_boundary = 1'b1;
                w_next     = (i_mode == MODE_SAT) ? i_limit : ZERO;
            end
        end else begin
            if (i_cur > i_limit) begin
                w_next = i_limit;
            end else if (i_cur == ZERO) begin
                w_boundary = 1'b1;
                w_next     = (i_mode == MODE_SAT) ? ZERO : i_limit;
            end else begin
                w_next = i_cur - ONE;
            end
        end
    end

    assign o_next     = w_next;
    assign o_boundary = w_boundary;

endmodule

// File: rtl/param_counter.sv
// Up/down counter with programmable limit, wrap/saturate modes, load,
// registered terminal-count pulse and sticky overflow flag.
module param_counter
    import param_counter_pkg::*;
#(
    parameter int unsigned     WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             T,
    input  logic             up,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             clr_ovf,
    output logic [WIDTH-1:0] out,
    output logic             tc,
    output logic             ovf
);

    logic [WIDTH-1:0] r_out;
    logic             r_tc;
    logic             r_ovf;
    logic [WIDTH-1:0] w_next;
    logic             w_bnd;
    act_e             w_act;

    param_counter_next #(.WIDTH(WIDTH)) u_next (
        .i_cur      (r_out),
        .i_up       (up),
        .i_mode     (mode),
        .i_limit    (limit),
        .o_next     (w_next),
        .o_boundary (w_bnd)
    );

    // Load outranks counting; reset is handled directly in the register block.
    always_comb begin
        w_act = ACT_HOLD;
        if (load) begin
            w_act = ACT_LOAD;
        end else if (T) begin
            w_act = ACT_STEP;
        end else begin
            w_act = ACT_HOLD;
        end
    end

    // Count, terminal-count and sticky-overflow registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_out <= INIT;
            r_tc  <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            case (w_act)
                ACT_LOAD: begin
                    r_out <= load_val;
                    r_tc  <= 1'b0;
                end
                ACT_STEP: begin
                    r_out <= w_next;
                    r_tc  <= w_bnd;
                end
                default: begin
                    r_out <= r_out;
                    r_tc  <= 1'b0;
                end
            endcase
            // A new event beats a simultaneous clear.
            if ((w_act == ACT_STEP) && w_bnd) begin
                r_ovf <= 1'b1;
            end else if (clr_ovf) begin
                r_ovf <= 1'b0;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    assign out = r_out;
    assign tc  = r_tc;
    assign ovf = r_ovf;

endmodule

// File: tb/tb_param_counter.sv
// Scoreboard bench: driver pushes reference-model expectations, monitor pops and compares each cycle.
module tb_param_counter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset = 1'b1, T = 1'b0, up = 1'b0, mode = 1'b0;
    logic         load = 1'b0, clr_ovf = 1'b0;
    logic [W-1:0] limit = '0, load_val = '0;
    logic [W-1:0] out;
    logic         tc, ovf;

    always #5 clk = ~clk;

    param_counter #(.WIDTH(W), .INIT(8'h00)) dut (
        .clk(clk), .reset(reset), .T(T), .up(up), .mode(mode),
        .limit(limit), .load(load), .load_val(load_val), .clr_ovf(clr_ovf),
        .out(out), .tc(tc), .ovf(ovf)
    );

    typedef struct {
        logic [W-1:0] out;
        logic         tc;
        logic         ovf;
        string        tag;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_e;
    int   n_cmp = 0;
    int   n_bad = 0;

    // Reference model state, in plain integers
    int   m_out = 0;
    bit   m_tc  = 1'b0;
    bit   m_ovf = 1'b0;

    task automatic chk(input string nm, input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s/%s: got 0x%0h expected 0x%0h at %0t", tag, nm, act, exp, $time);
        end
    endtask

    task automatic step(input bit rst, input bit t, input bit u, input bit md, input int lim,
                        input bit ld, input int lv, input bit clr, input string tag);
        exp_t e;
        bit   ev;
        @(negedge clk);
        reset = rst; T = t; up = u; mode = md; limit = lim[W-1:0];
        load = ld; load_val = lv[W-1:0]; clr_ovf = clr;
        ev = 1'b0;
        if (rst) begin
            m_out = 0; m_tc = 1'b0; m_ovf = 1'b0;
        end else begin
            if (ld) begin
                m_out = lv;
            end else if (t) begin
                if (u) begin
                    if (m_out < lim) m_out = m_out + 1;
                    else begin ev = 1'b1; m_out = md ? lim : 0; end
                end else if (m_out > lim) begin
                    m_out = lim;
                end else if (m_out == 0) begin
                    ev = 1'b1; m_out = md ? 0 : lim;
                end else begin
                    m_out = m_out - 1;
                end
            end
            m_tc  = ev;
            m_ovf = ev ? 1'b1 : (clr ? 1'b0 : m_ovf);
        end
        e.out = m_out[W-1:0]; e.tc = m_tc; e.ovf = m_ovf; e.tag = tag;
        sb_q.push_back(e);
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                mon_e = sb_q.pop_front();
                chk("out", mon_e.tag, 32'(out), 32'(mon_e.out));
                chk("tc",  mon_e.tag, 32'(tc),  32'(mon_e.tc));
                chk("ovf", mon_e.tag, 32'(ovf), 32'(mon_e.ovf));
            end
        end
    end

    initial begin
        int lim_r;
        // Reset dominates load and count
        step(1, 1, 1, 0, 9, 1, 8'h55, 0, "rst0");
        step(1, 1, 1, 0, 9, 1, 8'h55, 0, "rst1");
        // Wrap up through limit 9
        for (int i = 0; i < 10; i++) step(0, 1, 1, 0, 9, 0, 0, 0, "wrap_up");
        step(0, 0, 1, 0, 9, 0, 0, 1, "clr");
        // Saturate up at 255
        step(0, 0, 1, 1, 255, 1, 253, 0, "sat_ld");
        for (int i = 0; i < 4; i++) step(0, 1, 1, 1, 255, 0, 0, 0, "sat_up");
        // Down wrap and clamp from above limit
        step(0, 0, 0, 0, 5, 1, 0, 0, "dn_ld0");
        step(0, 1, 0, 0, 5, 0, 0, 0, "dn_wrap");
        step(0, 0, 0, 0, 5, 1, 200, 0, "dn_ld200");
        step(0, 1, 0, 0, 5, 0, 0, 0, "dn_clamp");
        // Collisions: load over count, set over clear
        step(0, 1, 1, 0, 9, 1, 8'h42, 0, "ld_vs_T");
        step(0, 1, 1, 0, 8'h42, 0, 0, 1, "set_vs_clr");
        // Mid-count reset discards a pending boundary event
        step(0, 0, 1, 0, 255, 1, 8'h36, 0, "mid_ld");
        step(0, 1, 1, 0, 8'h37, 0, 0, 0, "mid_up");
        step(1, 1, 1, 0, 8'h37, 0, 0, 0, "mid_rst");
        step(0, 0, 1, 0, 8'h37, 0, 0, 0, "mid_after");
        // limit == 0 in both modes and directions
        step(0, 1, 1, 1, 0, 0, 0, 0, "lim0_sat_up");
        step(0, 1, 1, 0, 0, 0, 0, 0, "lim0_wrap_up");
        step(0, 1, 0, 0, 0, 0, 0, 0, "lim0_wrap_dn");
        step(0, 1, 0, 1, 0, 0, 0, 0, "lim0_sat_dn");
        // Randomised traffic with boundary-heavy limits
        lim_r = 7;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 15) == 0) begin
                case ($urandom_range(0, 3))
                    0:       lim_r = 0;
                    1:       lim_r = 255;
                    2:       lim_r = int'($urandom_range(0, 255));
                    default: lim_r = int'($urandom_range(1, 12));
                endcase
            end
            step($urandom_range(0, 63) == 0, $urandom_range(0, 3) != 0,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1, lim_r,
                 $urandom_range(0, 9) == 0, int'($urandom_range(0, 255)),
                 $urandom_range(0, 7) == 0, "rand");
        end
        @(negedge clk);
        T = 1'b0; load = 1'b0; clr_ovf = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        n_cmp++;
        if (sb_q.size() != 0) begin
            n_bad++;
            $display("FAIL drain: got %0d pending expected 0", sb_q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
